// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline > long-latency FIFO head > debug,
// with a busy scoreboard for outstanding long-latency results and a starvation flag.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int DW           = 32,
    parameter int AW           = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              p_valid,
    input  logic [AW-1:0]     p_req_w,
    input  logic [DW-1:0]     p_data,
    input  logic              l_valid,
    output logic              l_ready,
    input  logic [AW-1:0]     l_req_w,
    input  logic [DW-1:0]     l_data,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [AW-1:0]     d_req_w,
    input  logic [DW-1:0]     d_data,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_set_reg,
    output logic [(1<<AW)-1:0] sb_busy,
    output logic              p_stall,
    output logic              err_waw,
    output logic              rf_w_en,
    output logic [AW-1:0]     rf_req_w,
    output logic [DW-1:0]     rf_data_w
);

    localparam int NREG = 1 << AW;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int SW   = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [AW-1:0] req_w;
        logic [DW-1:0] data;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [SW-1:0]     starve_cnt, starve_next;
    logic [NREG-1:0]   busy_set, busy_clr, busy_next;
    logic              p_write, fifo_empty, head_grant, enq, d_write;

    assign head       = mem[rd_ptr];
    assign p_write    = p_valid && (p_req_w != '0);
    assign fifo_empty = (count == '0);

    // Grants and handshakes are all gated by rst_n so nothing is written in a reset cycle.
    assign head_grant = rst_n && en && !p_write && !fifo_empty;
    assign l_ready    = rst_n && en && (count < CW'(DEPTH));
    assign d_ready    = rst_n && en && !p_write && fifo_empty;
    assign enq        = l_valid && l_ready && (l_req_w != '0);
    assign d_write    = d_valid && d_ready && (d_req_w != '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rf_w_en   = 1'b0;
        rf_req_w  = '0;
        rf_data_w = '0;
        if (rst_n && en && p_write) begin
            rf_w_en   = 1'b1;
            rf_req_w  = p_req_w;
            rf_data_w = p_data;
        end else if (head_grant) begin
            rf_w_en   = 1'b1;
            rf_req_w  = head.req_w;
            rf_data_w = head.data;
        end else if (d_write) begin
            rf_w_en   = 1'b1;
            rf_req_w  = d_req_w;
            rf_data_w = d_data;
        end
    end

    always_comb begin
        starve_next = starve_cnt;
        if (fifo_empty || head_grant)
            starve_next = '0;
        else if (p_write && (starve_cnt != SW'(STARVE_LIMIT)))
            starve_next = starve_cnt + 1'b1;
    end

    // Set wins over clear when both target the same register; r0 never reads busy.
    always_comb begin
        busy_set     = (sb_set && (sb_set_reg != '0)) ? (NREG'(1) << sb_set_reg) : '0;
        busy_clr     = head_grant ? (NREG'(1) << head.req_w) : '0;
        busy_next    = (sb_busy & ~busy_clr) | busy_set;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            p_stall    <= 1'b0;
            err_waw    <= 1'b0;
            sb_busy    <= '0;
        end else if (en) begin
            if (enq)        wr_ptr <= wr_ptr + 1'b1;
            if (head_grant) rd_ptr <= rd_ptr + 1'b1;
            count      <= count + CW'(enq) - CW'(head_grant);
            starve_cnt <= starve_next;
            p_stall    <= (starve_next == SW'(STARVE_LIMIT));
            if (p_write && sb_busy[p_req_w])
                err_waw <= 1'b1;
            sb_busy    <= busy_next;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (enq)
            mem[wr_ptr] <= '{req_w: l_req_w, data: l_data};
    end

endmodule
